// File: rtl/tag_fifo_if.sv
// Handshake bundle between the free-tag pool, the dispatcher and the CDB.
// The master side is the dispatcher/CDB; the slave side is the tag pool itself.
interface tag_fifo_if #(
    parameter int TAG_WIDTH = 6
);
    logic                 tagfifo_pop;
    logic [TAG_WIDTH-1:0] tagfifo_tag;
    logic                 tagfifo_empty;
    logic [TAG_WIDTH:0]   tagfifo_count;
    logic                 cdb_valid;
    logic [TAG_WIDTH-1:0] cdb_tag;
    logic                 tagfifo_err;

    modport master (
        output tagfifo_pop,
        output cdb_valid,
        output cdb_tag,
        input  tagfifo_tag,
        input  tagfifo_empty,
        input  tagfifo_count,
        input  tagfifo_err
    );

    modport slave (
        input  tagfifo_pop,
        input  cdb_valid,
        input  cdb_tag,
        output tagfifo_tag,
        output tagfifo_empty,
        output tagfifo_count,
        output tagfifo_err
    );
endinterface

// File: rtl/tag_fifo.sv
// Free destination-tag pool: strict FIFO of tags not owned by in-flight instructions,
// with an in-flight bitmap that rejects and flags illegal pops and releases.
module tag_fifo #(
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 2 ** TAG_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    tag_fifo_if.slave bus
);
    localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);
    localparam logic [TAG_WIDTH:0]   ZERO_COUNT = '0;
    localparam logic [TAG_WIDTH-1:0] LAST_PTR   = TAG_WIDTH'(DEPTH - 1);

    logic [TAG_WIDTH-1:0] mem_q [DEPTH];
    logic [TAG_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]     inflight_q, inflight_d;
    logic                 err_q, err_d;

    logic                 pop_ok, pop_bad;
    logic                 rel_ok, rel_bad;
    logic [TAG_WIDTH-1:0] head_tag;

    assign head_tag = mem_q[rd_ptr_q];

    // Every legality decision looks only at pre-edge register state, so a tag popped
    // this cycle is not yet in flight and a tag released this cycle is not yet poppable.
    assign pop_ok  = bus.tagfifo_pop && (count_q != ZERO_COUNT);
    assign pop_bad = bus.tagfifo_pop && (count_q == ZERO_COUNT);
    assign rel_ok  = bus.cdb_valid && inflight_q[bus.cdb_tag] && (count_q != FULL_COUNT);
    assign rel_bad = bus.cdb_valid && !rel_ok;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q | pop_bad | rel_bad;

        if (pop_ok) begin
            rd_ptr_d             = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            inflight_d[head_tag] = 1'b1;
        end
        // The popped head is never in flight, so it cannot collide with the released tag.
        if (rel_ok) begin
            wr_ptr_d                = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            inflight_d[bus.cdb_tag] = 1'b0;
        end

        unique case ({rel_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_WIDTH'(i);
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= FULL_COUNT;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (rel_ok) begin
                mem_q[wr_ptr_q] <= bus.cdb_tag;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign bus.tagfifo_tag   = head_tag;
    assign bus.tagfifo_empty = (count_q == ZERO_COUNT);
    assign bus.tagfifo_count = count_q;
    assign bus.tagfifo_err   = err_q;

endmodule
